// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate decoder behind a 2-entry skid FIFO; a push on an empty buffer appears one cycle later.
// o_ready is a flop (deasserted while both entries are held), so no combinational path runs from i_ready to o_ready.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic             i_signext,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [2:0]       o_fmt,
    output logic             o_illegal,
    output logic [TAG_W-1:0] o_tag
);
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_SH   = 3'd6;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [11:0] raw_i;
    logic [11:0] raw_s;
    logic [12:0] raw_b;
    logic [31:0] raw_u;
    logic [20:0] raw_j;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign raw_i  = i_instr[31:20];
    assign raw_s  = {i_instr[31:25], i_instr[11:7]};
    assign raw_b  = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign raw_u  = {i_instr[31:12], 12'b0};
    assign raw_j  = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;

    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        case (opcode)
            7'b0000011, 7'b1100111: begin
                dec_fmt = FMT_I;
                dec_imm = i_signext ? XLEN'($signed(raw_i)) : XLEN'(raw_i);
            end
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_fmt = FMT_SH;
                    // RV32 has only 5 shamt bits; bit 25 set is a reserved encoding there
                    if (XLEN == 64) begin
                        dec_imm = XLEN'(i_instr[25:20]);
                    end else begin
                        dec_imm = XLEN'(i_instr[24:20]);
                        dec_ill = i_instr[25];
                    end
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = i_signext ? XLEN'($signed(raw_i)) : XLEN'(raw_i);
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_imm = i_signext ? XLEN'($signed(raw_s)) : XLEN'(raw_s);
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_imm = i_signext ? XLEN'($signed(raw_b)) : XLEN'(raw_b);
            end
            7'b0110111, 7'b0010111: begin
                // U-type always sign-extends bit 31 on RV64, independent of i_signext
                dec_fmt = FMT_U;
                dec_imm = XLEN'($signed(raw_u));
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_imm = i_signext ? XLEN'($signed(raw_j)) : XLEN'(raw_j);
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
    end

    logic [XLEN-1:0]  imm_q [2];
    logic [2:0]       fmt_q [2];
    logic             ill_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic             head_q, head_d;
    logic [1:0]       count_q, count_d;
    logic             ready_q, ready_d;
    logic             tail;
    logic             push;
    logic             pop;

    assign push = i_valid & ready_q;
    assign pop  = (count_q != 2'd0) & i_ready;
    assign tail = head_q ^ count_q[0];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        head_d  = pop ? ~head_q : head_q;
        ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            ready_q <= 1'b1;
            for (int e = 0; e < 2; e++) begin
                imm_q[e] <= '0;
                fmt_q[e] <= FMT_NONE;
                ill_q[e] <= 1'b0;
                tag_q[e] <= '0;
            end
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            ready_q <= ready_d;
            if (push) begin
                imm_q[tail] <= dec_imm;
                fmt_q[tail] <= dec_fmt;
                ill_q[tail] <= dec_ill;
                tag_q[tail] <= i_tag;
            end
        end
    end

    // Outputs read zero whenever the buffer is empty, not stale entry contents
    assign o_valid   = (count_q != 2'd0);
    assign o_ready   = ready_q;
    assign o_imm     = o_valid ? imm_q[head_q] : '0;
    assign o_fmt     = o_valid ? fmt_q[head_q] : FMT_NONE;
    assign o_illegal = o_valid ? ill_q[head_q] : 1'b0;
    assign o_tag     = o_valid ? tag_q[head_q] : '0;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: an XLEN=32 instance for the main sequence and an XLEN=64 instance for RV64 cases.
module tb_imm_gen_pipe;
    logic        clk;
    logic        rst;

    logic        a_valid, a_ready_o, a_signext, a_valid_o, a_ready, a_ill;
    logic [31:0] a_instr, a_imm;
    logic [7:0]  a_tag, a_tag_o;
    logic [2:0]  a_fmt;

    logic        b_valid, b_ready_o, b_signext, b_valid_o, b_ready, b_ill;
    logic [31:0] b_instr;
    logic [63:0] b_imm;
    logic [7:0]  b_tag, b_tag_o;
    logic [2:0]  b_fmt;

    int total  = 0;
    int passed = 0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_ready(a_ready_o),
        .i_instr(a_instr), .i_signext(a_signext), .i_tag(a_tag),
        .o_valid(a_valid_o), .i_ready(a_ready), .o_imm(a_imm), .o_fmt(a_fmt),
        .o_illegal(a_ill), .o_tag(a_tag_o)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_ready_o),
        .i_instr(b_instr), .i_signext(b_signext), .i_tag(b_tag),
        .o_valid(b_valid_o), .i_ready(b_ready), .o_imm(b_imm), .o_fmt(b_fmt),
        .o_illegal(b_ill), .o_tag(b_tag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h, expected %h", name, obs, exp);
    endtask

    task automatic drv(input logic v, input logic [31:0] instr, input logic sx,
                       input logic [7:0] tag, input logic rdy);
        a_valid   = v;
        a_instr   = instr;
        a_signext = sx;
        a_tag     = tag;
        a_ready   = rdy;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [31:0] imm, input logic [2:0] fmt,
                           input logic ill, input logic [7:0] tag);
        chk({name, ".vld"}, a_valid_o, 1'b1);
        chk({name, ".imm"}, a_imm, imm);
        chk({name, ".fmt"}, a_fmt, fmt);
        chk({name, ".ill"}, a_ill, ill);
        chk({name, ".tag"}, a_tag_o, tag);
    endtask

    initial begin
        rst = 1'b1;
        drv(1'b0, 32'h0, 1'b0, 8'h0, 1'b0);
        b_valid = 1'b0; b_instr = 32'h0; b_signext = 1'b0; b_tag = 8'h0; b_ready = 1'b0;
        #3;
        chk("rst.vld", a_valid_o, 1'b0);
        chk("rst.rdy", a_ready_o, 1'b1);
        chk("rst.imm", a_imm, 32'h0);
        chk("rst.fmt", a_fmt, 3'd0);
        chk("rst.ill", a_ill, 1'b0);
        chk("rst.tag", a_tag_o, 8'h0);
        #9 rst = 1'b0;
        cyc();

        // Sign control on I-type, then the remaining formats back to back
        drv(1'b1, 32'hFFF00093, 1'b1, 8'h10, 1'b1); cyc();
        chk_out("i_sx1", 32'hFFFFFFFF, 3'd1, 1'b0, 8'h10);
        drv(1'b1, 32'hFFF00093, 1'b0, 8'h11, 1'b1); cyc();
        chk_out("i_sx0", 32'h00000FFF, 3'd1, 1'b0, 8'h11);
        drv(1'b1, 32'hFE112E23, 1'b1, 8'h12, 1'b1); cyc();
        chk_out("sw", 32'hFFFFFFFC, 3'd2, 1'b0, 8'h12);
        drv(1'b1, 32'hFE000CE3, 1'b1, 8'h13, 1'b1); cyc();
        chk_out("beq", 32'hFFFFFFF8, 3'd3, 1'b0, 8'h13);
        drv(1'b1, 32'h123450B7, 1'b1, 8'h14, 1'b1); cyc();
        chk_out("lui", 32'h12345000, 3'd4, 1'b0, 8'h14);
        drv(1'b1, 32'h0010006F, 1'b1, 8'h15, 1'b1); cyc();
        chk_out("jal", 32'h00000800, 3'd5, 1'b0, 8'h15);
        drv(1'b1, 32'h00000033, 1'b1, 8'h55, 1'b1); cyc();
        chk_out("rtype", 32'h0, 3'd0, 1'b1, 8'h55);
        drv(1'b1, 32'h02009093, 1'b1, 8'h56, 1'b1); cyc();
        chk_out("slli_bad", 32'h0, 3'd6, 1'b1, 8'h56);
        drv(1'b0, 32'h0, 1'b0, 8'h0, 1'b1); cyc();
        chk("drain.vld", a_valid_o, 1'b0);

        // Backpressure: third tag must wait until the buffer frees a slot
        drv(1'b1, 32'h00100093, 1'b1, 8'h01, 1'b0); cyc();
        chk("bp1.rdy", a_ready_o, 1'b1);
        chk("bp1.tag", a_tag_o, 8'h01);
        drv(1'b1, 32'h00100093, 1'b1, 8'h02, 1'b0); cyc();
        chk("bp2.rdy", a_ready_o, 1'b0);
        chk("bp2.tag", a_tag_o, 8'h01);
        drv(1'b1, 32'h00100093, 1'b1, 8'h03, 1'b0); cyc();
        chk("bp3.rdy", a_ready_o, 1'b0);
        chk("bp3.tag", a_tag_o, 8'h01);
        chk("bp3.imm", a_imm, 32'h1);
        drv(1'b1, 32'h00100093, 1'b1, 8'h03, 1'b1); cyc();
        chk("bp4.tag", a_tag_o, 8'h02);
        chk("bp4.rdy", a_ready_o, 1'b1);
        cyc();
        chk("bp5.tag", a_tag_o, 8'h03);
        chk("bp5.vld", a_valid_o, 1'b1);
        drv(1'b0, 32'h0, 1'b0, 8'h0, 1'b1); cyc();
        chk("bp6.vld", a_valid_o, 1'b0);

        // Steady push+pop with one entry resident
        drv(1'b1, 32'h00700093, 1'b1, 8'h20, 1'b1); cyc();
        for (int i = 1; i <= 10; i++) begin
            drv(1'b1, 32'h00700093, 1'b1, 8'(8'h20 + i), 1'b1); cyc();
            chk("stream.tag", a_tag_o, 64'(8'h20 + i));
            chk("stream.rdy", a_ready_o, 1'b1);
        end
        drv(1'b0, 32'h0, 1'b0, 8'h0, 1'b1); cyc();
        chk("stream.drain", a_valid_o, 1'b0);

        // Asynchronous reset with the buffer full
        drv(1'b1, 32'hFFF00093, 1'b1, 8'h40, 1'b0); cyc();
        drv(1'b1, 32'hFFF00093, 1'b1, 8'h41, 1'b0); cyc();
        chk("full.rdy", a_ready_o, 1'b0);
        drv(1'b0, 32'h0, 1'b0, 8'h0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst.vld", a_valid_o, 1'b0);
        chk("arst.rdy", a_ready_o, 1'b1);
        chk("arst.imm", a_imm, 32'h0);
        chk("arst.tag", a_tag_o, 8'h0);
        chk("arst.fmt", a_fmt, 3'd0);
        #1 rst = 1'b0;
        drv(1'b1, 32'hFE112E23, 1'b1, 8'h77, 1'b1); cyc();
        chk_out("post_rst", 32'hFFFFFFFC, 3'd2, 1'b0, 8'h77);
        drv(1'b0, 32'h0, 1'b0, 8'h0, 1'b1); cyc();

        // RV64 instance
        b_ready = 1'b1; b_valid = 1'b1;
        b_instr = 32'h800000B7; b_signext = 1'b0; b_tag = 8'hA0; cyc();
        chk("rv64_lui.imm", b_imm, 64'hFFFFFFFF80000000);
        chk("rv64_lui.fmt", b_fmt, 3'd4);
        b_instr = 32'h03F09093; b_tag = 8'hA1; cyc();
        chk("rv64_slli.imm", b_imm, 64'd63);
        chk("rv64_slli.ill", b_ill, 1'b0);
        chk("rv64_slli.fmt", b_fmt, 3'd6);
        b_instr = 32'hFFF00093; b_signext = 1'b1; b_tag = 8'hA2; cyc();
        chk("rv64_addi.imm", b_imm, 64'hFFFFFFFFFFFFFFFF);
        chk("rv64_addi.tag", b_tag_o, 8'hA2);
        chk("rv64_addi.vld", b_valid_o, 1'b1);
        chk("rv64_addi.rdy", b_ready_o, 1'b1);
        b_valid = 1'b0; cyc();
        chk("rv64_drain", b_valid_o, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate decoder.
- Decodes every RV32I/RV64I immediate format (I, S, B, U including AUIPC, J, shift-amount) from a full instruction word. Opcode is taken from i_instr[6:0]; there is no separate opcode input.
- Sits between fetch and the execute-operand mux. Has a valid/ready handshake on both sides and a 2-entry skid buffer, so decode can absorb backpressure without a combinational ready path.
- Flags unsupported opcodes instead of emitting X.

Parameters:
- XLEN, 32, immediate output width. Legal values: 32, 64.
- TAG_W, 8, width of the sideband tag (e.g. ROB or PC index) carried alongside each instruction.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  upstream instruction valid.
- o_ready  output  1  block can accept this cycle. Registered.
- i_instr  input  32  instruction word.
- i_signext  input  1  1 = sign-extend I/S/B/J immediates; 0 = zero-extend.
- i_tag  input  TAG_W  sideband tag, passed through unmodified.
- o_valid  output  1  output entry valid.
- i_ready  input  1  downstream accepts.
- o_imm  output  XLEN  decoded immediate.
- o_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SH.
- o_illegal  output  1  unsupported opcode or bad shamt.
- o_tag  output  TAG_W  tag of the output entry.

Behaviour:
- Reset (asynchronous, i_rst=1): buffer count := 0; o_valid=0; o_ready=1; o_imm, o_fmt, o_illegal, o_tag = 0. Any entries in flight are discarded.
- Push occurs when i_valid & o_ready. Pop occurs when o_valid & i_ready.
- The immediate is decoded combinationally at push time and written into the buffer.
- Latency: a push in cycle N is visible on the outputs in cycle N+1 when the buffer was empty.
- Buffer is a 2-entry FIFO with strict in-order output.
  - o_valid = (count != 0).
  - o_ready = (count != 2), registered from the next-count value.
- Count updates:
  - push without pop: count+1.
  - pop without push: count-1.
  - push and pop together: unchanged; head advances and the new entry is written to the tail.
  - At count=2 no push can occur.
- Outputs are driven from the head entry and stay stable while o_valid & !i_ready.
- Format decode by opcode:
  - 0000011 (load), 1100111 (JALR), 0010011 (non-shift op-imm): I, imm[11:0] = instr[31:20].
  - 0010011 with funct3 001 or 101: SH.
    - XLEN=32: imm = instr[24:20], zero-extended. instr[25]=1 sets o_illegal.
    - XLEN=64: imm = instr[25:20], zero-extended.
  - 0100011: S, imm = {instr[31:25], instr[11:7]}.
  - 1100011: B, imm = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 0110111 (LUI), 0010111 (AUIPC): U, imm = {instr[31:12], 12'b0}. When XLEN=64, bit 31 is always sign-extended, regardless of i_signext.
  - 1101111: J, imm = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Any other opcode: fmt=NONE, imm=0, o_illegal=1. The entry is still pushed and popped normally.
- Extension rule for I/S/B/J: the MSB of the raw field is replicated up to XLEN when i_signext=1; otherwise upper bits are 0.
- Tag and illegal flag travel with their entry.
- i_signext is sampled at push time only.

Test Plan:
- Sign control, I-type: push 0xFFF00093 (addi x1,x0,-1) with signext=1 and then signext=0, i_ready=1 → o_imm=0xFFFFFFFF, then 0x00000FFF; fmt=1; each appears one cycle after its push.
- Formats: push in order 0xFE112E23 (sw, -4), 0xFE000CE3 (beq, -8), 0x123450B7 (lui), 0x0010006F (jal, +2048) → o_imm = 0xFFFFFFFC/S, 0xFFFFFFF8/B, 0x12345000/U, 0x00000800/J; o_illegal=0 throughout.
- Illegal opcode: push 0x00000033 (R-type) → o_fmt=0, o_imm=0, o_illegal=1, tag preserved. With XLEN=32, push slli 0x02009093 (shamt bit 25 set) → fmt=6, o_illegal=1.
- Backpressure: hold i_ready=0, drive i_valid=1 with tags 1,2,3 → only tags 1 and 2 are accepted; o_ready=0 in the cycle after the second push; outputs hold tag 1. Release i_ready → tags 1, 2, 3 emerge in order with no loss or duplication.
- Simultaneous push/pop: with count=1 and continuous valid/ready for 10 cycles → count stays 1; one output per cycle; sequence intact.
- Reset mid-operation: assert i_rst asynchronously with 2 entries held → o_valid drops immediately, o_ready=1, all outputs 0; the first push after release emerges correctly.
- XLEN=64 build: lui 0x800000B7 → o_imm=0xFFFFFFFF80000000; slli with shamt 63 → imm=63, o_illegal=0.
